// File: rtl/conv_input_sequencer.sv
// conv_input_sequencer
// Streams one weight set, one bias word and one input image from a
// 1-cycle-latency word memory onto the convolution layer's 32-bit
// newDataPacket bus, qualified by one-hot weights/bias/input strobes.
// Lane contents are never inspected; words pass through untouched.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start with non-zero dimensions
// WEIGHTS | one weight read per cycle at weightBase + count, never stalled
// BIAS    | single read at biasAddr
// PIXELS  | one pixel read per cycle at pixelBase + count while stall = 0
// DRAIN   | no reads; wait for the last read to leave the memory stage
// DONE    | pulse done for one cycle, then return to IDLE

module conv_input_sequencer #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            inputDim,
    input  logic [1:0]            windowDim,
    input  logic [ADDR_WIDTH-1:0] weightBase,
    input  logic [ADDR_WIDTH-1:0] biasAddr,
    input  logic [ADDR_WIDTH-1:0] pixelBase,
    input  logic                  stall,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rd_data,
    output logic [31:0]           newDataPacket,
    output logic                  weights_valid,
    output logic                  bias_valid,
    output logic                  input_valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WEIGHTS = 3'd1,
        S_BIAS    = 3'd2,
        S_PIXELS  = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Read-type tag that travels alongside each memory read.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_W    = 2'd1,
        TAG_B    = 2'd2,
        TAG_P    = 2'd3
    } tag_t;

    state_t                  state_q, state_d;

    // Configuration captured on the accepted start cycle.
    logic [1:0]              win_dim_q;
    logic [7:0]              in_dim_q;
    logic [ADDR_WIDTH-1:0]   weight_base_q;
    logic [ADDR_WIDTH-1:0]   bias_addr_q;
    logic [ADDR_WIDTH-1:0]   pixel_base_q;
    logic                    cfg_load;

    // Read counters (up-counters, since they also form the address offset).
    logic [3:0]              wcnt_q, wcnt_d;
    logic [15:0]             pcnt_q, pcnt_d;
    logic [3:0]              w_last;
    logic [15:0]             p_last;

    logic [ADDR_WIDTH-1:0]   weight_addr;
    logic [ADDR_WIDTH-1:0]   pixel_addr;

    // Read issue and the tag pipeline.
    tag_t                    rd_tag;
    tag_t                    tag_s1_q;
    logic [31:0]             pkt_q;
    logic                    weights_valid_q;
    logic                    bias_valid_q;
    logic                    input_valid_q;

    // Terminal counts for the two read phases; dimensions are non-zero
    // whenever these are used, so the minus-one never underflows in use.
    assign w_last = 4'({2'b00, win_dim_q} * {2'b00, win_dim_q}) - 4'd1;
    assign p_last = 16'({8'h00, in_dim_q} * {8'h00, in_dim_q}) - 16'd1;

    // Address arithmetic wraps silently modulo 2^ADDR_WIDTH.
    assign weight_addr = weight_base_q + ADDR_WIDTH'(wcnt_q);
    assign pixel_addr  = pixel_base_q + ADDR_WIDTH'(pcnt_q);

    // Next-state, counter and read-issue decode.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        pcnt_d    = pcnt_q;
        cfg_load  = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        rd_tag    = TAG_NONE;

        case (state_q)
            S_IDLE: begin
                if (start && (windowDim != 2'd0) && (inputDim != 8'd0)) begin
                    cfg_load = 1'b1;
                    wcnt_d   = 4'd0;
                    pcnt_d   = 16'd0;
                    state_d  = S_WEIGHTS;
                end
            end

            S_WEIGHTS: begin
                mem_rd_en = 1'b1;
                mem_addr  = weight_addr;
                rd_tag    = TAG_W;
                if (wcnt_q == w_last) begin
                    wcnt_d  = 4'd0;
                    state_d = S_BIAS;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end

            S_BIAS: begin
                mem_rd_en = 1'b1;
                mem_addr  = bias_addr_q;
                rd_tag    = TAG_B;
                state_d   = S_PIXELS;
            end

            S_PIXELS: begin
                if (!stall) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = pixel_addr;
                    rd_tag    = TAG_P;
                    if (pcnt_q == p_last) begin
                        pcnt_d  = 16'd0;
                        state_d = S_DRAIN;
                    end else begin
                        pcnt_d = pcnt_q + 16'd1;
                    end
                end
            end

            // The last pixel read is one stage deep on entry; once the
            // memory stage is empty its strobe is going out this cycle.
            S_DRAIN: begin
                if (tag_s1_q == TAG_NONE) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            pcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // Configuration capture; later input changes are invisible to the run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_dim_q     <= 2'd0;
            in_dim_q      <= 8'd0;
            weight_base_q <= '0;
            bias_addr_q   <= '0;
            pixel_base_q  <= '0;
        end else if (cfg_load) begin
            win_dim_q     <= windowDim;
            in_dim_q      <= inputDim;
            weight_base_q <= weightBase;
            bias_addr_q   <= biasAddr;
            pixel_base_q  <= pixelBase;
        end
    end

    // Tag follows its read into the memory stage; the data word and the
    // matching strobe are registered together one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_s1_q        <= TAG_NONE;
            pkt_q           <= 32'd0;
            weights_valid_q <= 1'b0;
            bias_valid_q    <= 1'b0;
            input_valid_q   <= 1'b0;
        end else begin
            tag_s1_q        <= rd_tag;
            weights_valid_q <= (tag_s1_q == TAG_W);
            bias_valid_q    <= (tag_s1_q == TAG_B);
            input_valid_q   <= (tag_s1_q == TAG_P);
            if (tag_s1_q != TAG_NONE) begin
                pkt_q <= mem_rd_data;
            end
        end
    end

    assign newDataPacket = pkt_q;
    assign weights_valid = weights_valid_q;
    assign bias_valid    = bias_valid_q;
    assign input_valid   = input_valid_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

endmodule

// File: doc/conv_input_sequencer.md
# conv_input_sequencer

Stream source for the convolutional layer. On a start pulse it reads one weight set, one bias word and one input image from a 1-cycle-latency word memory. It drives them onto the layer's 32-bit `newDataPacket` bus with the matching `weights_valid` / `bias_valid` / `input_valid` strobes. Each 32-bit word carries four 8-bit lanes, one per unrolled convolution engine (lane k = bits [8k+7:8k]); the sequencer never inspects lane contents.

## Interface
- `ADDR_WIDTH`, 16: memory word-address width.
- `clock` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request to begin a sequence; sampled only in IDLE.
- `inputDim` in 8: image side length in pixel words; sequence sends inputDim*inputDim pixel words.
- `windowDim` in 2: kernel side length; sequence sends windowDim*windowDim weight words.
- `weightBase`, `biasAddr`, `pixelBase` in ADDR_WIDTH: word addresses, latched at start.
- `stall` in 1: downstream hold; suppresses new pixel reads only.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out ADDR_WIDTH: read address, valid with `mem_rd_en`.
- `mem_rd_data` in 32: read data, valid the cycle after `mem_rd_en`.
- `newDataPacket` out 32: registered data word to layer.
- `weights_valid`, `bias_valid`, `input_valid` out 1: one-hot strobes qualifying `newDataPacket`.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse after the last pixel strobe.

## Operation
- States:
  - IDLE
  - WEIGHTS: issue windowDim² reads at weightBase+0..N-1, one per cycle, never stalled.
  - BIAS: issue one read at biasAddr.
  - PIXELS: issue inputDim² reads at pixelBase+0..P-1, one per cycle when `stall`=0.
  - DRAIN: no reads; wait for the in-flight word to emerge.
  - DONE: pulse `done`, then return to IDLE.
- On `start`=1 in IDLE:
  - If windowDim≠0 and inputDim≠0: latch all config, go to WEIGHTS.
  - Otherwise ignore it and stay in IDLE.
- `start` outside IDLE is ignored. Config input changes after the start cycle have no effect.
- Read-type tag (W/B/P) pipelines with each read. Two cycles after a read, `newDataPacket` holds its data and exactly that tag's strobe is high for one cycle.
- Counters:
  - Weight counter 4 bits (max 9).
  - Pixel counter 16 bits (max 255² = 65025).
  - Address = base + counter, truncated to ADDR_WIDTH; wraps modulo 2^ADDR_WIDTH with no error.
- `stall` in WEIGHTS or BIAS has no effect. In PIXELS, `stall`=1 holds `mem_rd_en`=0 and the counter frozen. Reads already issued still produce their strobes.
- `busy` = 1 in every state except IDLE.

## Timing
- Reset: state IDLE, counters 0. All outputs 0: `mem_rd_en`, `mem_addr`, `newDataPacket`, the three strobes, `busy`, `done`. Pipeline tags cleared.
- Reset asserted mid-sequence aborts at once: no further strobes, no `done`.
- With `start` accepted at cycle 0 and no stall:
  - Cycles 1..N: weight reads.
  - Cycle N+1: bias read.
  - Cycles N+2..N+P+1: pixel reads.
  - First `weights_valid` at cycle 3.
  - Last `input_valid` at cycle N+P+3.
  - `done` at cycle N+P+4, with `busy` still 1.
  - IDLE at cycle N+P+5; a new `start` is accepted from that cycle.
- Read-to-strobe latency is fixed at 2 cycles.
- Strobes are never simultaneous; `newDataPacket` holds its last value when no strobe is high.
- A stall on the final pixel read delays DRAIN entry until the read issues.

## Test plan
- Reset, windowDim=3, inputDim=4, bases 0x10/0x20/0x40, no stall:
  - 9 `weights_valid` at cycles 3–11 carrying mem[0x10..0x18].
  - `bias_valid` at 12 with mem[0x20].
  - 16 `input_valid` at 13–28 carrying mem[0x40..0x4F].
  - `done` at 29, `busy` 0 at 30.
- Same config with `stall` high for cycles 15–17:
  - Pixel reads pause for exactly 3 cycles.
  - All 16 pixel words still delivered in order.
  - `done` at 32.
  - `stall` during weight reads changes nothing.
- windowDim=0 or inputDim=0 with `start`: `busy` stays 0, no `mem_rd_en`, no strobes.
- `start` pulsed again mid-sequence and config inputs changed after cycle 0: output stream identical to the undisturbed run.
- `reset` asserted at cycle 8 of a run: all outputs 0 in the same cycle. A fresh start afterward completes normally.
- pixelBase=0xFFFE (ADDR_WIDTH=16), inputDim=2: pixel addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
